// File: rtl/am_lock_if.sv
// Signal bundle between the upstream AM detector / error monitor and am_lock_fsm.
// Plain level signals sampled on fullclk; there is no backpressure on this path.
interface am_lock_if;
    logic       in_isam;
    logic [2:0] in_am_field;
    logic       clr_err;
    logic       am_lock;
    logic [1:0] lane_id;
    logic       am_valid;
    logic       fec_frame_start;
    logic [7:0] am_err_cnt;

    modport master (
        output in_isam, in_am_field, clr_err,
        input  am_lock, lane_id, am_valid, fec_frame_start, am_err_cnt
    );

    modport slave (
        input  in_isam, in_am_field, clr_err,
        output am_lock, lane_id, am_valid, fec_frame_start, am_err_cnt
    );
endinterface

// File: rtl/am_lock_fsm.sv
// Alignment-marker lock FSM: hunts for an AM, verifies it one period later,
// then tracks AM slots and FEC frame boundaries while locked.
module am_lock_fsm #(
    parameter int AM_PERIOD  = 39600,
    parameter int FEC_LEN    = 1320,
    parameter int MISS_LIMIT = 3
) (
    input  logic       fullclk,
    input  logic       rst,
    am_lock_if.slave   bus,
    output logic [1:0] dbg_state
);
    localparam int PW = (AM_PERIOD > 1) ? $clog2(AM_PERIOD) : 1;
    localparam int FW = (FEC_LEN > 1) ? $clog2(FEC_LEN) : 1;
    localparam logic [PW-1:0] POS_LAST = PW'(AM_PERIOD - 1);
    localparam logic [PW-1:0] POS_ONE  = PW'((AM_PERIOD > 1) ? 1 : 0);
    localparam logic [FW-1:0] FEC_LAST = FW'(FEC_LEN - 1);
    localparam logic [FW-1:0] FEC_ONE  = FW'((FEC_LEN > 1) ? 1 : 0);
    localparam logic [3:0]    MISS_MAX = 4'(MISS_LIMIT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [FW-1:0] fec_q, fec_d;
    logic [3:0]    miss_q, miss_d;
    logic [1:0]    lane_q, lane_d;
    logic [7:0]    err_q, err_d;
    logic          lock_d, valid_d, fs_d;
    logic          valid_smp, hit, slot, err_inc;

    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        miss_d    = miss_q;
        lane_d    = lane_q;
        valid_d   = 1'b0;
        err_inc   = 1'b0;
        valid_smp = bus.in_isam && !bus.in_am_field[2];
        hit       = valid_smp && (bus.in_am_field[1:0] == lane_q);
        slot      = (state_q != HUNT) && (pos_q == '0);
        pos_d     = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
        // FEC count restarts whenever the AM period wraps so it stays frame-aligned.
        fec_d     = (fec_q == FEC_LAST || pos_q == POS_LAST) ? '0 : fec_q + FW'(1);

        case (state_q)
            HUNT: begin
                if (valid_smp) begin
                    state_d = VERIFY;
                    lane_d  = bus.in_am_field[1:0];
                    pos_d   = POS_ONE;
                    fec_d   = FEC_ONE;
                end
            end
            VERIFY: begin
                if (slot) begin
                    if (hit) begin
                        state_d = LOCKED;
                        miss_d  = '0;
                        valid_d = 1'b1;
                    end else begin
                        state_d = HUNT;
                        err_inc = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (slot) begin
                    if (hit) begin
                        valid_d = 1'b1;
                        miss_d  = '0;
                    end else begin
                        err_inc = 1'b1;
                        miss_d  = miss_q + 4'd1;
                        if (miss_q + 4'd1 == MISS_MAX) state_d = HUNT;
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        lock_d = (state_d == LOCKED);
        // Suppress the frame pulse on the edge that drops lock so it never outlives am_lock.
        fs_d   = (state_q == LOCKED) && (fec_q == '0) && (state_d == LOCKED);

        if (bus.clr_err)                   err_d = '0;
        else if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;
        else                               err_d = err_q;
    end

    always_ff @(posedge fullclk) begin
        if (rst) begin
            state_q             <= HUNT;
            pos_q               <= '0;
            fec_q               <= '0;
            miss_q              <= '0;
            lane_q              <= '0;
            err_q               <= '0;
            bus.am_lock         <= 1'b0;
            bus.am_valid        <= 1'b0;
            bus.fec_frame_start <= 1'b0;
        end else begin
            state_q             <= state_d;
            pos_q               <= pos_d;
            fec_q               <= fec_d;
            miss_q              <= miss_d;
            lane_q              <= lane_d;
            err_q               <= err_d;
            bus.am_lock         <= lock_d;
            bus.am_valid        <= valid_d;
            bus.fec_frame_start <= fs_d;
        end
    end

    assign bus.lane_id    = lane_q;
    assign bus.am_err_cnt = err_q;
endmodule

// File: tb/tb_am_lock_fsm.sv
// Bench for am_lock_fsm: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a cycle-indexed behavioural model.
module tb_am_lock_fsm;
    localparam int P = 40;
    localparam int F = 10;
    localparam int L = 3;

    logic       fullclk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    am_lock_if bus();

    am_lock_fsm #(.AM_PERIOD(P), .FEC_LEN(F), .MISS_LIMIT(L)) dut (
        .fullclk   (fullclk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    always #5 fullclk = ~fullclk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: mode 0=hunting, 1=verifying, 2=locked; slots are multiples of P after the capture cycle.
    int m_mode   = 0;
    int m_anchor = 0;
    int m_lane   = 0;
    int m_miss   = 0;
    int m_err    = 0;

    logic [12:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d obs=%0d exp=%0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit m_slot_now();
        return (m_mode != 0) && (cyc > m_anchor) && (((cyc - m_anchor) % P) == 0);
    endfunction

    task automatic model_step(input bit r, input bit isam, input int field, input bit clr);
        bit vs, hit, slot, fecz, inc, v, fs;
        vs   = isam && (field <= 3);
        hit  = vs && (field == m_lane);
        slot = m_slot_now();
        fecz = (m_mode == 2) && (((cyc - m_anchor) % F) == 0);
        inc  = 0;
        v    = 0;
        if (r) begin
            m_mode = 0; m_lane = 0; m_miss = 0; m_err = 0;
            exp_q.push_back(13'd0);
            return;
        end
        if (m_mode == 0) begin
            if (vs) begin
                m_mode = 1; m_anchor = cyc; m_lane = field;
            end
        end else if (slot) begin
            if (hit) begin
                v = 1; m_miss = 0; m_mode = 2;
            end else begin
                inc = 1;
                if (m_mode == 1) m_mode = 0;
                else begin
                    m_miss++;
                    if (m_miss >= L) m_mode = 0;
                end
            end
        end
        fs = fecz && (m_mode == 2);
        if (clr) m_err = 0;
        else if (inc && m_err < 255) m_err++;
        exp_q.push_back({(m_mode == 2), 2'(m_lane), v, fs, 8'(m_err)});
    endtask

    task automatic drive(input bit r, input bit isam, input int field, input bit clr);
        logic [12:0] e;
        rst             = r;
        bus.in_isam     = isam;
        bus.in_am_field = field[2:0];
        bus.clr_err     = clr;
        @(posedge fullclk);
        model_step(r, isam, field, clr);
        cyc++;
        #1;
        e = exp_q.pop_front();
        check_val("am_lock", bus.am_lock, e[12]);
        check_val("lane_id", bus.lane_id, e[11:10]);
        check_val("am_valid", bus.am_valid, e[9]);
        check_val("fec_frame_start", bus.fec_frame_start, e[8]);
        check_val("am_err_cnt", bus.am_err_cnt, e[7:0]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 7, 0);
    endtask

    task automatic am(input int field);
        drive(0, 1, field, 0);
    endtask

    task automatic do_reset();
        // Random inputs during reset must be ignored.
        for (int i = 0; i < 3; i++) drive(1, 1, $urandom_range(0, 7), $urandom_range(0, 1));
    endtask

    initial begin
        do_reset();
        check_val("reset_lock", bus.am_lock, 0);
        check_val("reset_err", bus.am_err_cnt, 0);

        // Acquire: AM at cycles 5 and 45, lock from 46, frame pulse at 56.
        idle(5);
        am(2);
        idle(39);
        am(2);
        check_val("acq_lock", bus.am_lock, 1);
        check_val("acq_lane", bus.lane_id, 2);
        check_val("acq_valid", bus.am_valid, 1);
        idle(10);
        check_val("acq_fec56", bus.fec_frame_start, 1);

        // Lose lock after three consecutive missed slots.
        idle(29); idle(1);
        check_val("miss1_err", bus.am_err_cnt, 1);
        idle(39); idle(1);
        check_val("miss2_err", bus.am_err_cnt, 2);
        check_val("miss2_lock", bus.am_lock, 1);
        idle(39); idle(1);
        check_val("miss3_err", bus.am_err_cnt, 3);
        check_val("miss3_lock", bus.am_lock, 0);

        // Two misses then a hit keeps lock; the miss count restarts.
        do_reset();
        am(1); idle(39); am(1);
        idle(39); idle(1); idle(39); idle(1);
        idle(39); am(1);
        check_val("recover_lock", bus.am_lock, 1);
        idle(39); idle(1); idle(39); idle(1);
        check_val("recover_still", bus.am_lock, 1);

        // Verify failure with a stray AM at pos 20, then restart capture.
        do_reset();
        am(0); idle(19); am(3); idle(19); am(1);
        check_val("vfail_lock", bus.am_lock, 0);
        check_val("vfail_err", bus.am_err_cnt, 1);
        am(1); idle(39); am(1);
        check_val("vfail_relock", bus.am_lock, 1);

        // Field 7 is not a capture.
        do_reset();
        drive(0, 1, 7, 0); idle(39); drive(0, 1, 7, 0);
        check_val("f7_lock", bus.am_lock, 0);

        // Saturation, then clear winning over a coincident failing slot.
        do_reset();
        for (int k = 0; k < 300; k++) begin
            am(0); idle(39); am(1);
        end
        check_val("sat_err", bus.am_err_cnt, 255);
        am(0); idle(39); drive(0, 1, 1, 1);
        check_val("clr_err", bus.am_err_cnt, 0);

        // Reset pulse while locked.
        am(3); idle(39); am(3); idle(10);
        drive(1, 0, 7, 0);
        check_val("rst_lock", bus.am_lock, 0);
        check_val("rst_lane", bus.lane_id, 0);

        // Randomized traffic biased toward slot-aligned AMs.
        for (int i = 0; i < 4000; i++) begin
            bit r, isam, clr;
            int field, roll;
            r     = ($urandom_range(0, 999) < 3);
            clr   = ($urandom_range(0, 99) < 1);
            roll  = $urandom_range(0, 99);
            field = $urandom_range(0, 7);
            isam  = 0;
            if (m_slot_now()) begin
                if (roll < 70) begin isam = 1; field = m_lane; end
                else if (roll < 85) isam = 1;
            end else if (roll < 4) begin
                isam = 1;
            end
            drive(r, isam, field, clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/am_lock_fsm.md
AM_LOCK_FSM -- requirements
Module: am_lock_fsm

Interface
REQ-001 Parameter AM_PERIOD, default 39600, is the bit-clock spacing between consecutive alignment markers.
REQ-002 Parameter FEC_LEN, default 1320, is the FEC frame length in bit clocks; AM_PERIOD SHALL be an integer multiple of FEC_LEN.
REQ-003 Parameter MISS_LIMIT, default 3, is the number of consecutive missed AMs that drops lock; legal range 1..15.
REQ-004 Port fullclk, input, 1 bit: sole clock, one serial bit per rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in_isam, input, 1 bit: AM-detected strobe from the upstream AM detector, same cycle as in_am_field.
REQ-007 Port in_am_field, input, 3 bits: detected AM index 0..3; 7 means none.
REQ-008 Port clr_err, input, 1 bit: synchronous clear of am_err_cnt.
REQ-009 Port am_lock, output, 1 bit: AM alignment lock acquired.
REQ-010 Port lane_id, output, 2 bits: AM index of the locked lane.
REQ-011 Port am_valid, output, 1 bit: one-cycle pulse, expected AM confirmed.
REQ-012 Port fec_frame_start, output, 1 bit: one-cycle pulse marking the first bit of each FEC frame while locked.
REQ-013 Port am_err_cnt, output, 8 bits: saturating count of failed AM slots.

Function
REQ-014 The block SHALL implement states HUNT, VERIFY and LOCKED; all outputs SHALL be registered.
REQ-015 A sample is valid only if in_isam=1 and in_am_field<=3; in_isam=1 with in_am_field 4..7 SHALL be treated as no AM.
REQ-016 Position counter pos, 0..AM_PERIOD-1: on the HUNT capture edge pos<=1; on every other edge pos increments and wraps AM_PERIOD-1 -> 0.
REQ-017 The "slot" SHALL be any cycle in VERIFY or LOCKED where pos==0.
REQ-018 HUNT: on a valid sample, lane_id<=in_am_field, pos<=1, state->VERIFY; otherwise remain in HUNT.
REQ-019 VERIFY: samples outside the slot SHALL be ignored.
REQ-020 VERIFY slot, valid sample with field==lane_id: state->LOCKED, am_lock<=1, am_valid pulses on the next cycle, miss counter<=0.
REQ-021 VERIFY slot, any other input: state->HUNT, am_err_cnt increments, am_lock stays 0.
REQ-022 LOCKED slot, match: am_valid pulses, miss counter<=0.
REQ-023 LOCKED slot, no match: am_err_cnt increments, miss counter increments; when the counter reaches MISS_LIMIT, state->HUNT and am_lock<=0 on the same edge.
REQ-024 LOCKED samples outside the slot SHALL be ignored; lane_id SHALL hold its value while in LOCKED.
REQ-025 FEC counter: cleared at each slot, counts 0..FEC_LEN-1 and wraps; fec_frame_start pulses the cycle after a cycle where state is LOCKED and the FEC counter is 0.
REQ-026 fec_frame_start and am_valid SHALL be 0 whenever am_lock is 0.
REQ-027 am_err_cnt SHALL saturate at 255.
REQ-028 If clr_err and an increment coincide, clear SHALL win (result 0).
REQ-029 Latency from slot input to am_lock, am_valid or am_err_cnt update SHALL be exactly one clock.

Reset
REQ-030 While rst=1 at an edge: state<=HUNT, pos<=0, miss counter<=0, FEC counter<=0, am_lock<=0, lane_id<=0, am_valid<=0, fec_frame_start<=0, am_err_cnt<=0.
REQ-031 rst asserted mid-operation SHALL abort lock, with outputs at reset values from the next cycle; inputs are ignored during reset.

Verification (AM_PERIOD=40, FEC_LEN=10, MISS_LIMIT=3)
REQ-032 Acquire: after reset, valid AM field 2 at cycles 5 and 45 -> am_lock=1 and lane_id=2 from cycle 46; am_valid pulses at cycle 46; fec_frame_start pulses at 56, 66, 76, 86.
REQ-033 Lose lock: while locked, omit AMs at 3 consecutive slots -> am_err_cnt reads 1, 2, 3; am_lock falls one cycle after the 3rd slot. A separate run with 2 misses then a hit -> lock is kept and miss counter resets.
REQ-034 Verify failure: second AM arrives at the slot with field 1 against captured field 0 -> state HUNT, am_lock=0, am_err_cnt=1; the next valid AM restarts capture. A stray AM at pos 20 in VERIFY is ignored.
REQ-035 Saturation and clear: 300 consecutive VERIFY failures -> am_err_cnt=255; clr_err coincident with a failing slot -> am_err_cnt=0.
REQ-036 Robustness: in_isam=1 with in_am_field=7 in HUNT -> no capture; rst pulse while locked -> all outputs 0 on the next cycle.
